keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clock cycles each column is driven while scanning.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles needed to accept a press or a release.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port rows, input, 4: keypad rows, active-low, externally pulled up.
REQ-006 SHALL have port cols, output, 4: column drive, active-low, exactly one bit low at all times.
REQ-007 SHALL have port key, output, 4: hex value of the last accepted key.
REQ-008 SHALL have port key_valid, output, 1: one-cycle pulse when a press is accepted.
REQ-009 SHALL have port key_held, output, 1: high from press acceptance until release acceptance.

Function
REQ-010 SHALL map keys by (row,col) as follows: row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = E,0,F,D.
REQ-011 SHALL implement FSM states SCAN, DEBOUNCE, HELD and RELEASE.
REQ-012 In SCAN: cols rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110 every SCAN_DIV cycles, wrapping from column 3 to column 0.
REQ-013 In SCAN, rows SHALL be sampled on the last dwell cycle of each column; any low row captures (row,col), freezes cols and enters DEBOUNCE.
REQ-014 If more than one row is low at sampling, the lowest-index row SHALL win.
REQ-015 In DEBOUNCE: the captured row must read low for DEBOUNCE_CYCLES consecutive cycles, then key updates, key_valid pulses once, and the FSM enters HELD.
REQ-016 A high on the captured row during DEBOUNCE SHALL clear the counter, return to SCAN at the next column, and produce no pulse and no key change.
REQ-017 In HELD: key_held=1 and cols stays frozen; a high on the captured row enters RELEASE.
REQ-018 In RELEASE: the row must read high for DEBOUNCE_CYCLES consecutive cycles, then key_held=0 and SCAN resumes at column (captured+1) mod 4.
REQ-019 Any low on the captured row during RELEASE SHALL return to HELD with no new key_valid pulse.
REQ-020 key SHALL retain its last value after release, until the next accepted press.
REQ-021 Presses on other keys while the FSM is in DEBOUNCE, HELD or RELEASE SHALL be ignored.
REQ-022 Counters SHALL be sized $clog2 of their parameter and SHALL saturate rather than wrap.

Reset
REQ-023 On reset low, the block SHALL immediately set: state=SCAN, cols=1110, key=0, key_valid=0, key_held=0, all counters=0.
REQ-024 Reset asserted mid-press SHALL drop key_held and key_valid at once; after release of reset, scanning restarts at column 0.

Configuration
REQ-025 With macro KEYPAD_SYNC_EN defined, rows SHALL pass through a two-flop synchronizer before any use, adding 2 cycles of latency to every row-based decision.
REQ-026 With KEYPAD_SYNC_EN undefined, rows SHALL be used directly, with no added latency.

Structure
REQ-027 Package keypad_pkg SHALL hold the FSM state enum, the 4x4 key-map constant and the cols reset value.
REQ-028 The synchronizer SHALL be sub-module sync2, a 4-bit, two-flop synchronizer with asynchronous active-low reset.

Verification (bench uses SCAN_DIV=4, DEBOUNCE_CYCLES=8, KEYPAD_SYNC_EN undefined)
REQ-029 Reset then idle rows=1111 for 40 cycles -> cols cycles 1110,1101,1011,0111 with period 4 per column; key_valid never asserts.
REQ-030 Hold row1 low while col2 is driven, for at least 8 cycles -> exactly one key_valid pulse, key=6, key_held=1, cols frozen at 1011.
REQ-031 Bounce row0/col0 low 3 cycles, high 1 cycle, low 3 cycles, then high -> no key_valid; key stays 0; scanning resumes.
REQ-032 Hold row3/col1 through acceptance, then release for at least 8 cycles -> key=0, key_held falls, next cols=1011.
REQ-033 Rows 0 and 2 both low on col3 -> key=A.
REQ-034 Assert reset while key_held=1 -> outputs return to their reset values in the same cycle; cols=1110.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Holds the FSM state encoding, the key map, the column reset pattern and small decode helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_e;

    localparam logic [3:0] COLS_RESET = 4'b1110;

    // Indexed by {row, col}; element 0 is row0/col0.
    localparam logic [0:15][3:0] KEY_MAP = {
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic [1:0] col_index(input logic [3:0] cols);
        logic [1:0] idx;
        case (cols)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    // Lowest-index low row wins when several rows are pulled down together.
    function automatic logic [1:0] first_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        if (!rows[0])      idx = 2'd0;
        else if (!rows[1]) idx = 2'd1;
        else if (!rows[2]) idx = 2'd2;
        else               idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/sync2.sv
// Four-bit two-flop synchronizer for the keypad row inputs.
// Asynchronous active-low reset leaves both stages at the idle (pulled-up) level.
module sync2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 4'hF;
            sync_q <= 4'hF;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and hex key output.
// Define KEYPAD_SYNC_EN to route rows through sync2 (adds two cycles to every row decision).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0] rows_s;

`ifdef KEYPAD_SYNC_EN
    sync2 u_sync2 (
        .clk   (clk),
        .reset (reset),
        .d_i   (rows),
        .q_o   (rows_s)
    );
`else
    assign rows_s = rows;
`endif

    state_e           state_q,     state_d;
    logic [3:0]       cols_q,      cols_d;
    logic [1:0]       row_q,       row_d;
    logic [DIV_W-1:0] div_q,       div_d;
    logic [DEB_W-1:0] deb_q,       deb_d;
    logic [3:0]       key_q,       key_d;
    logic             key_valid_q, key_valid_d;

    logic       row_high;
    logic [3:0] cols_next;

    assign row_high  = rows_s[row_q];
    assign cols_next = {cols_q[2:0], cols_q[3]};

    // Counters only advance below their terminal value, so they saturate instead of wrapping.
    always_comb begin
        state_d     = state_q;
        cols_d      = cols_q;
        row_d       = row_q;
        div_d       = div_q;
        deb_d       = deb_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        case (state_q)
            ST_SCAN: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!(&rows_s)) begin
                        row_d   = first_low_row(rows_s);
                        deb_d   = '0;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        cols_d = cols_next;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                if (row_high) begin
                    deb_d   = '0;
                    div_d   = '0;
                    cols_d  = cols_next;
                    state_d = ST_SCAN;
                end else if (deb_q == DEB_LAST) begin
                    deb_d       = '0;
                    key_d       = KEY_MAP[{row_q, col_index(cols_q)}];
                    key_valid_d = 1'b1;
                    state_d     = ST_HELD;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            ST_HELD: begin
                if (row_high) begin
                    deb_d   = '0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!row_high) begin
                    deb_d   = '0;
                    state_d = ST_HELD;
                end else if (deb_q == DEB_LAST) begin
                    deb_d   = '0;
                    div_d   = '0;
                    cols_d  = cols_next;
                    state_d = ST_SCAN;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_SCAN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_SCAN;
            cols_q      <= COLS_RESET;
            row_q       <= 2'd0;
            div_q       <= '0;
            deb_q       <= '0;
            key_q       <= 4'h0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cols_q      <= cols_d;
            row_q       <= row_d;
            div_q       <= div_d;
            deb_q       <= deb_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign cols      = cols_q;
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign key_held  = (state_q == ST_HELD) || (state_q == ST_RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad model drives rows from pressed keys,
// expected key codes are queued by the stimulus and popped by a monitor on each key_valid pulse.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;

    logic [15:0] press_mask = '0;
    logic [3:0]  exp_q [$];
    logic [3:0]  col_pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;

    keypad_scanner #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // A pressed key at (r,c) pulls row r low whenever column c is driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (press_mask[r*4+c] && !cols[c]) rows[r] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] e;
        if (reset && key_valid) begin
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_key_valid: key=%h, no press expected", key);
            end else begin
                e = exp_q.pop_front();
                $display("key_valid pulse: key=%h expected=%h", key, e);
                if (key !== e) begin
                    errors++;
                    $display("FAIL pulse_key: got %h required %h", key, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_cols(input logic [3:0] target, input string name);
        int n = 0;
        while (cols !== target && n < 40) begin
            cyc(1);
            n++;
        end
        chk(name, {28'd0, cols}, {28'd0, target});
    endtask

    task automatic wait_pulse(input int p0, input string name);
        int n = 0;
        while (pulses == p0 && n < 60) begin
            cyc(1);
            n++;
        end
        chk(name, pulses, p0 + 1);
    endtask

    task automatic wait_release(input string name);
        int n = 0;
        while (key_held && n < 40) begin
            cyc(1);
            n++;
        end
        chk(name, {31'd0, key_held}, 32'd0);
    endtask

    initial begin
        int p0;
        cyc(3);
        chk("reset_cols", {28'd0, cols}, 32'hE);
        chk("reset_key", {28'd0, key}, 32'h0);
        chk("reset_valid", {31'd0, key_valid}, 32'd0);
        chk("reset_held", {31'd0, key_held}, 32'd0);
        reset = 1'b1;

        // Idle scan: column index advances every SCAN_DIV cycles.
        for (int n = 1; n <= 40; n++) begin
            cyc(1);
            chk("idle_cols", {28'd0, cols}, {28'd0, col_pat[(n / SCAN_DIV) % 4]});
        end

        // Bounce on row0/col0: capture, then a one-cycle high aborts debounce.
        wait_cols(4'b1110, "bounce_wait_col0");
        cyc(2);
        press_mask[0] = 1'b1;
        cyc(3);
        press_mask[0] = 1'b0;
        cyc(1);
        chk("bounce_abort_cols", {28'd0, cols}, 32'hD);
        press_mask[0] = 1'b1;
        cyc(3);
        press_mask[0] = 1'b0;
        cyc(1);
        chk("bounce_resume_cols", {28'd0, cols}, 32'hB);
        chk("bounce_key", {28'd0, key}, 32'h0);
        chk("bounce_held", {31'd0, key_held}, 32'd0);

        // Key 6 at row1/col2.
        exp_q.push_back(4'h6);
        p0 = pulses;
        press_mask[6] = 1'b1;
        wait_pulse(p0, "key6_pulse");
        chk("key6_key", {28'd0, key}, 32'h6);
        chk("key6_held", {31'd0, key_held}, 32'd1);
        chk("key6_cols", {28'd0, cols}, 32'hB);
        cyc(5);
        chk("key6_held_later", {31'd0, key_held}, 32'd1);
        chk("key6_cols_frozen", {28'd0, cols}, 32'hB);
        chk("key6_single_pulse", pulses, p0 + 1);
        press_mask = '0;
        wait_release("key6_release");
        chk("key6_resume_cols", {28'd0, cols}, 32'h7);
        chk("key6_key_retained", {28'd0, key}, 32'h6);

        // Key 0 at row3/col1, then release resumes at column 2.
        wait_cols(4'b1101, "key0_wait_col1");
        exp_q.push_back(4'h0);
        p0 = pulses;
        press_mask[13] = 1'b1;
        wait_pulse(p0, "key0_pulse");
        chk("key0_key", {28'd0, key}, 32'h0);
        chk("key0_held", {31'd0, key_held}, 32'd1);
        press_mask = '0;
        wait_release("key0_release");
        chk("key0_resume_cols", {28'd0, cols}, 32'hB);
        chk("key0_key_retained", {28'd0, key}, 32'h0);

        // Rows 0 and 2 on column 3: row 0 wins, giving A.
        wait_cols(4'b0111, "keyA_wait_col3");
        exp_q.push_back(4'hA);
        p0 = pulses;
        press_mask[3]  = 1'b1;
        press_mask[11] = 1'b1;
        wait_pulse(p0, "keyA_pulse");
        chk("keyA_key", {28'd0, key}, 32'hA);
        chk("keyA_held", {31'd0, key_held}, 32'd1);

        // Reset while held clears outputs immediately.
        reset = 1'b0;
        #1;
        chk("midreset_held", {31'd0, key_held}, 32'd0);
        chk("midreset_valid", {31'd0, key_valid}, 32'd0);
        chk("midreset_key", {28'd0, key}, 32'h0);
        chk("midreset_cols", {28'd0, cols}, 32'hE);
        press_mask = '0;
        cyc(2);
        reset = 1'b1;
        cyc(1);
        chk("postreset_cols0", {28'd0, cols}, 32'hE);
        cyc(3);
        chk("postreset_cols1", {28'd0, cols}, 32'hD);

        cyc(2);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
